// File: rtl/pipe_pkg.sv
// Purpose: shared types and constants for the pipeline hazard controller.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package pipe_pkg;
    localparam int REG_NO_W = 5;

    typedef enum logic [1:0] {
        RUN     = 2'd0,
        MD_WAIT = 2'd1,
        MD_WB   = 2'd2
    } state_t;
endpackage

// File: rtl/sat_counter.sv
// Purpose: up-counter that sticks at all-ones, with synchronous clear.
// Latency: count visible the cycle after inc.
// Backpressure: none; clear has priority over inc.
module sat_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         clr,
    input  logic         inc,
    input  logic         clear,
    output logic [W-1:0] cnt
);
    // Count up on inc, hold at all-ones, clear on request.
    always_ff @(posedge clk or posedge clr) begin
        if (clr)
            cnt <= '0;
        else if (clear)
            cnt <= '0;
        else if (inc && (cnt != {W{1'b1}}))
            cnt <= cnt + 1'b1;
    end
endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Purpose: stall/flush sequencer merging ID hazards with the mul/div handshake and WB port arbitration.
// Latency: all control outputs are combinational in the current cycle; state advances on clk.
// Backpressure: freezes PC/IF-ID (wpcir=0) and bubbles ID->EX on any stall; a mul/div result waits for a free WB slot.
module pipe_hazard_ctrl
    import pipe_pkg::*;
#(
    parameter int STARVE = 4,
    parameter int CNTW   = 16
) (
    input  logic                clk,
    input  logic                clr,
    input  logic                load_depen,
    input  logic                d_jump,
    input  logic                d_bmp,
    input  logic                d_md,
    input  logic [REG_NO_W-1:0] d_rs,
    input  logic [REG_NO_W-1:0] d_rt,
    input  logic                d_use_rs,
    input  logic                d_use_rt,
    input  logic [REG_NO_W-1:0] d_rn,
    input  logic                md_done,
    input  logic                wb_wreg,
    output logic                wpcir,
    output logic                id_bubble,
    output logic                if_flush,
    output logic                md_go,
    output logic                md_busy,
    output logic                md_wsel,
    output logic [REG_NO_W-1:0] md_wrn,
    output logic [CNTW-1:0]     stall_cnt
);
    localparam int SW = $clog2(STARVE + 1);
    localparam logic [SW-1:0] STARVE_MAX = SW'(STARVE);
    localparam logic [SW-1:0] STARVE_M1  = SW'(STARVE - 1);

    state_t        state, state_nxt;
    logic [SW-1:0] starve_cnt;
    logic          starve_inc;
    logic          go_c, wsel_c, busy_c;
    logic          dep, dep_stall, force_bubble, stall;

    // Mode register; reset abandons any outstanding mul/div op.
    always_ff @(posedge clk or posedge clr) begin
        if (clr)
            state <= RUN;
        else
            state <= state_nxt;
    end

    // Destination of the issued mul/div, captured at issue.
    always_ff @(posedge clk or posedge clr) begin
        if (clr)
            md_wrn <= '0;
        else if (go_c)
            md_wrn <= d_rn;
    end

    assign busy_c = (state != RUN);
    assign dep    = busy_c && (md_wrn != '0) &&
                    ((d_use_rs && (d_rs == md_wrn)) || (d_use_rt && (d_rt == md_wrn)));

    // Next state, issue/write-grant and hazard qualification.
    always_comb begin
        state_nxt    = state;
        go_c         = 1'b0;
        wsel_c       = 1'b0;
        dep_stall    = 1'b0;
        force_bubble = 1'b0;
        starve_inc   = 1'b0;
        case (state)
            RUN: begin
                if (d_md && !load_depen) begin
                    go_c      = 1'b1;
                    state_nxt = MD_WAIT;
                end
            end
            MD_WAIT: begin
                dep_stall = dep;
                if (md_done)
                    state_nxt = MD_WB;
            end
            MD_WB: begin
                if (!wb_wreg) begin
                    // Write lands on the falling edge, so ID sees the value now.
                    wsel_c    = 1'b1;
                    state_nxt = RUN;
                end else begin
                    dep_stall    = dep;
                    starve_inc   = (starve_cnt != STARVE_MAX);
                    force_bubble = (starve_cnt == STARVE_M1);
                end
            end
            default: state_nxt = RUN;
        endcase
    end

    assign stall = load_depen || dep_stall || (d_md && busy_c) || force_bubble;

    assign wpcir     = clr || !stall;
    assign id_bubble = !clr && stall;
    assign if_flush  = !clr && (d_jump || d_bmp) && !stall;
    assign md_go     = !clr && go_c;
    assign md_busy   = !clr && busy_c;
    assign md_wsel   = !clr && wsel_c;

    // Cycles the result has waited for WB; held at zero outside MD_WB.
    sat_counter #(.W(SW)) u_starve (
        .clk   (clk),
        .clr   (clr),
        .inc   (starve_inc),
        .clear (state != MD_WB),
        .cnt   (starve_cnt)
    );

    // Frozen-pipeline cycle statistic.
    sat_counter #(.W(CNTW)) u_stall_cnt (
        .clk   (clk),
        .clr   (clr),
        .inc   (!wpcir),
        .clear (1'b0),
        .cnt   (stall_cnt)
    );
endmodule
